// File: rtl/fpalu_pkg.sv
// Shared definitions for the FP ALU arbiter: FS opcodes, FSM states and the
// per-opcode latency lookup.
package fpalu_pkg;

    localparam logic [4:0] FS_PASS_S = 5'h00;
    localparam logic [4:0] FS_PASS_T = 5'h01;
    localparam logic [4:0] FS_ADD    = 5'h02;
    localparam logic [4:0] FS_SUB    = 5'h03;
    localparam logic [4:0] FS_ZERO   = 5'h13;
    localparam logic [4:0] FS_MULT   = 5'h1E;
    localparam logic [4:0] FS_DIV    = 5'h1F;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    // Illegal opcodes still complete, with the shortest latency.
    function automatic int unsigned lat_of(input logic [4:0] fs, input int unsigned lat_pass,
                                           input int unsigned lat_add, input int unsigned lat_mul,
                                           input int unsigned lat_div);
        case (fs)
            FS_PASS_S, FS_PASS_T, FS_ZERO: lat_of = lat_pass;
            FS_ADD, FS_SUB:                lat_of = lat_add;
            FS_MULT:                       lat_of = lat_mul;
            FS_DIV:                        lat_of = lat_div;
            default:                       lat_of = 1;
        endcase
    endfunction

endpackage

// File: rtl/fpalu_64.sv
// Combinational IEEE-754 double ALU: pass, zero, add/sub, multiply, divide.
// Round-to-nearest-even; subnormal inputs and results are flushed to zero.
module fpalu_64
    import fpalu_pkg::*;
(
    input  logic [4:0]  fs,
    input  logic [63:0] s,
    input  logic [63:0] t,
    output logic [63:0] y,
    output logic        err
);

    localparam logic [63:0] QNAN  = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] QUIET = 64'h0008_0000_0000_0000;

    // m: hidden bit at [55], fraction [54:3], guard/round/sticky [2:0].
    function automatic logic [63:0] round_pack(input logic sgn, input logic signed [13:0] e,
                                               input logic [55:0] m);
        logic [53:0]        mr;
        logic signed [13:0] er;
        mr = {1'b0, m[55:3]} + 54'(m[2] & (m[1] | m[0] | m[3]));
        er = e;
        if (mr[53]) begin
            mr = mr >> 1;
            er = er + 14'sd1;
        end
        if (er >= 14'sd2047)
            round_pack = {sgn, 11'h7FF, 52'd0};
        else if (er <= 14'sd0 || !mr[52])
            round_pack = {sgn, 63'd0};
        else
            round_pack = {sgn, er[10:0], mr[51:0]};
    endfunction

    logic        sa, sb, sb_eff;
    logic [10:0] ea, eb;
    logic [51:0] fa, fb;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign {sa, ea, fa} = s;
    assign {sb, eb, fb} = t;
    assign sb_eff = sb ^ (fs == FS_SUB);
    assign nan_a  = (ea == 11'h7FF) && (fa != 52'd0);
    assign nan_b  = (eb == 11'h7FF) && (fb != 52'd0);
    assign inf_a  = (ea == 11'h7FF) && (fa == 52'd0);
    assign inf_b  = (eb == 11'h7FF) && (fb == 52'd0);
    assign zero_a = (ea == 11'd0);
    assign zero_b = (eb == 11'd0);

    logic               bg_s, sm_s;
    logic [10:0]        bg_e, sm_e, dexp;
    logic [52:0]        bg_m, sm_m;
    logic [55:0]        sm_al, sm_sh;
    logic [56:0]        sum;
    logic [55:0]        nrm;
    logic [5:0]         lz;
    logic signed [13:0] e_add;
    logic [63:0]        add_y;

    always_comb begin
        if ({ea, fa} >= {eb, fb}) begin
            bg_s = sa;     bg_e = ea; bg_m = {1'b1, fa};
            sm_s = sb_eff; sm_e = eb; sm_m = {1'b1, fb};
        end else begin
            bg_s = sb_eff; bg_e = eb; bg_m = {1'b1, fb};
            sm_s = sa;     sm_e = ea; sm_m = {1'b1, fa};
        end
        dexp  = bg_e - sm_e;
        sm_sh = {sm_m, 3'b000} >> dexp;
        if (dexp >= 11'd56)
            sm_al = 56'd1;
        else
            sm_al = {sm_sh[55:1], sm_sh[0] | (({sm_m, 3'b000} & ((56'd1 << dexp) - 56'd1)) != 56'd0)};
        e_add = $signed({3'b000, bg_e});
        lz    = 6'd56;
        nrm   = 56'd0;
        if (bg_s == sm_s) begin
            sum = {1'b0, bg_m, 3'b000} + {1'b0, sm_al};
            if (sum[56]) begin
                nrm   = {sum[56:2], sum[1] | sum[0]};
                e_add = e_add + 14'sd1;
            end else begin
                nrm = sum[55:0];
            end
            add_y = round_pack(bg_s, e_add, nrm);
        end else begin
            sum = {1'b0, bg_m, 3'b000} - {1'b0, sm_al};
            for (int i = 0; i < 56; i++)
                if (sum[i]) lz = 6'(55 - i);
            nrm   = sum[55:0] << lz;
            e_add = e_add - $signed({8'd0, lz});
            add_y = (sum == 57'd0) ? 64'd0 : round_pack(bg_s, e_add, nrm);
        end
    end

    logic [105:0]       prod;
    logic [55:0]        m_mul;
    logic signed [13:0] e_mul;
    logic [63:0]        mul_y;

    always_comb begin
        prod  = 106'({1'b1, fa}) * 106'({1'b1, fb});
        e_mul = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 14'sd1023;
        if (prod[105]) begin
            m_mul = {prod[105:51], |prod[50:0]};
            e_mul = e_mul + 14'sd1;
        end else begin
            m_mul = {prod[104:50], |prod[49:0]};
        end
        mul_y = round_pack(sa ^ sb, e_mul, m_mul);
    end

    // Quotient of two [1,2) mantissas scaled by 2^56 lands with its top bit at 56 or 55.
    logic [108:0]       num, rem;
    logic [56:0]        quo;
    logic [55:0]        m_div;
    logic signed [13:0] e_div;
    logic [63:0]        div_y;

    always_comb begin
        num   = {1'b1, fa, 56'd0};
        quo   = 57'(num / 109'({1'b1, fb}));
        rem   = num % 109'({1'b1, fb});
        e_div = $signed({3'b000, ea}) - $signed({3'b000, eb}) + 14'sd1023;
        if (quo[56]) begin
            m_div = {quo[56:2], (|quo[1:0]) | (rem != 109'd0)};
        end else begin
            m_div = {quo[55:1], quo[0] | (rem != 109'd0)};
            e_div = e_div - 14'sd1;
        end
        div_y = round_pack(sa ^ sb, e_div, m_div);
    end

    always_comb begin
        y   = 64'd0;
        err = 1'b0;
        case (fs)
            FS_PASS_S: y = s;
            FS_PASS_T: y = t;
            FS_ZERO:   y = 64'd0;
            FS_ADD, FS_SUB: begin
                if (nan_a)                               y = s | QUIET;
                else if (nan_b)                          y = t | QUIET;
                else if (inf_a && inf_b && sa != sb_eff) y = QNAN;
                else if (inf_a)                          y = s;
                else if (inf_b)                          y = {sb_eff, t[62:0]};
                else if (zero_a && zero_b)               y = {sa & sb_eff, 63'd0};
                else if (zero_a)                         y = {sb_eff, t[62:0]};
                else if (zero_b)                         y = s;
                else                                     y = add_y;
            end
            FS_MULT: begin
                if (nan_a)                                      y = s | QUIET;
                else if (nan_b)                                 y = t | QUIET;
                else if ((inf_a && zero_b) || (zero_a && inf_b)) y = QNAN;
                else if (inf_a || inf_b)                        y = {sa ^ sb, 11'h7FF, 52'd0};
                else if (zero_a || zero_b)                      y = {sa ^ sb, 63'd0};
                else                                            y = mul_y;
            end
            FS_DIV: begin
                if (nan_a)                                       y = s | QUIET;
                else if (nan_b)                                  y = t | QUIET;
                else if ((inf_a && inf_b) || (zero_a && zero_b)) y = QNAN;
                else if (inf_a || zero_b)                        y = {sa ^ sb, 11'h7FF, 52'd0};
                else if (zero_a || inf_b)                        y = {sa ^ sb, 63'd0};
                else                                             y = div_y;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpalu_arbiter.sv
// Round-robin share of one FP ALU between two requesters; one op in flight,
// per-opcode modelled latency, result held until the consumer takes it.
module fpalu_arbiter
    import fpalu_pkg::*;
#(
    parameter int unsigned LAT_PASS = 1,
    parameter int unsigned LAT_ADD  = 2,
    parameter int unsigned LAT_MUL  = 4,
    parameter int unsigned LAT_DIV  = 12,
    parameter int unsigned CNT_W    = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [9:0]     req_fs,
    input  logic [127:0]   req_s,
    input  logic [127:0]   req_t,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           res_id,
    output logic [63:0]    res_y,
    output logic           res_err
);

    state_e             state_q, state_d;
    logic [4:0]         fs_q, fs_d;
    logic [63:0]        s_q, s_d, t_q, t_d;
    logic               id_q, id_d, last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               res_valid_q, res_valid_d, res_id_q, res_id_d, res_err_q, res_err_d;
    logic [63:0]        res_y_q, res_y_d;
    logic               gnt, take;
    logic [63:0]        alu_y;
    logic               alu_err;

    // last_q resets to 1 so requester 0 wins the first tie.
    assign gnt  = (&req_valid) ? ~last_q : req_valid[1];
    assign take = (state_q == IDLE) && (|req_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = EXEC;
            EXEC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (take) req_ready = gnt ? 2'b10 : 2'b01;
    end

    always_comb begin
        fs_d        = fs_q;
        s_d         = s_q;
        t_d         = t_q;
        id_d        = id_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_y_d     = res_y_q;
        res_err_d   = res_err_q;
        case (state_q)
            IDLE: if (take) begin
                fs_d   = gnt ? req_fs[9:5]    : req_fs[4:0];
                s_d    = gnt ? req_s[127:64]  : req_s[63:0];
                t_d    = gnt ? req_t[127:64]  : req_t[63:0];
                id_d   = gnt;
                last_d = gnt;
                cnt_d  = CNT_W'(lat_of(fs_d, LAT_PASS, LAT_ADD, LAT_MUL, LAT_DIV) - 1);
            end
            EXEC: if (cnt_q == '0) begin
                res_y_d     = alu_y;
                res_err_d   = alu_err;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            DONE: if (res_ready) res_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fs_q        <= '0;
            s_q         <= '0;
            t_q         <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_y_q     <= '0;
            res_err_q   <= 1'b0;
        end else begin
            fs_q        <= fs_d;
            s_q         <= s_d;
            t_q         <= t_d;
            id_q        <= id_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_y_q     <= res_y_d;
            res_err_q   <= res_err_d;
        end
    end

    fpalu_64 u_alu (
        .fs  (fs_q),
        .s   (s_q),
        .t   (t_q),
        .y   (alu_y),
        .err (alu_err)
    );

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_y     = res_y_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_fpalu_arbiter.sv
// Directed bench for fpalu_arbiter with a cycle-level reference model checked
// on every falling edge.
module tb_fpalu_arbiter;

    localparam logic [63:0] D1_0  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] D1_5  = 64'h3FF8_0000_0000_0000;
    localparam logic [63:0] D2_0  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D2_25 = 64'h4002_0000_0000_0000;
    localparam logic [63:0] D3_0  = 64'h4008_0000_0000_0000;
    localparam logic [63:0] D4_0  = 64'h4010_0000_0000_0000;
    localparam logic [63:0] D5_0  = 64'h4014_0000_0000_0000;
    localparam logic [63:0] DM2_0 = 64'hC000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [9:0]   req_fs = '0;
    logic [127:0] req_s = '0;
    logic [127:0] req_t = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic         res_id;
    logic [63:0]  res_y;
    logic         res_err;

    int n_chk = 0;
    int n_fail = 0;

    fpalu_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_fs    (req_fs),
        .req_s     (req_s),
        .req_t     (req_t),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_y     (res_y),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int mlat(input logic [4:0] fs);
        case (fs)
            5'h00, 5'h01, 5'h13: mlat = 1;
            5'h02, 5'h03:        mlat = 2;
            5'h1E:               mlat = 4;
            5'h1F:               mlat = 12;
            default:             mlat = 1;
        endcase
    endfunction

    // {err, y} from real arithmetic; stimulus uses exactly representable values.
    function automatic logic [64:0] mres(input logic [4:0] fs, input logic [63:0] s, input logic [63:0] t);
        real a, b;
        a = $bitstoreal(s);
        b = $bitstoreal(t);
        case (fs)
            5'h00:   mres = {1'b0, s};
            5'h01:   mres = {1'b0, t};
            5'h02:   mres = {1'b0, $realtobits(a + b)};
            5'h03:   mres = {1'b0, $realtobits(a - b)};
            5'h13:   mres = {1'b0, 64'd0};
            5'h1E:   mres = {1'b0, $realtobits(a * b)};
            5'h1F:   mres = {1'b0, $realtobits(a / b)};
            default: mres = {1'b1, 64'd0};
        endcase
    endfunction

    // Model: phase 0 idle, 1 computing (m_rem cycles to go), 2 result held.
    int          m_ph = 0;
    int          m_rem = 0;
    logic        m_last = 1'b1, m_pid = 1'b0, m_perr = 1'b0;
    logic        m_valid = 1'b0, m_id = 1'b0, m_err = 1'b0;
    logic [63:0] m_y = '0, m_py = '0;

    always @(negedge clk) begin : cmp
        logic [1:0]  er;
        logic        g;
        logic [4:0]  mfs;
        logic [64:0] r;
        if (!reset_n) begin
            chk("rst.ready", 64'(req_ready), 64'd0);
            chk("rst.valid", 64'(res_valid), 64'd0);
            chk("rst.y",     res_y,          64'd0);
            chk("rst.id",    64'(res_id),    64'd0);
            chk("rst.err",   64'(res_err),   64'd0);
            m_ph = 0; m_last = 1'b1; m_valid = 1'b0; m_y = '0; m_id = 1'b0; m_err = 1'b0;
        end else begin
            er = 2'b00;
            if (m_ph == 0 && req_valid != 2'b00)
                er = (req_valid == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req_valid;
            chk("model.ready", 64'(req_ready), 64'(er));
            chk("model.valid", 64'(res_valid), 64'(m_valid));
            chk("model.y",     res_y,          m_y);
            chk("model.id",    64'(res_id),    64'(m_id));
            chk("model.err",   64'(res_err),   64'(m_err));
            case (m_ph)
                0: if (er != 2'b00) begin
                    g      = er[1];
                    mfs    = g ? req_fs[9:5] : req_fs[4:0];
                    r      = mres(mfs, g ? req_s[127:64] : req_s[63:0], g ? req_t[127:64] : req_t[63:0]);
                    m_py   = r[63:0];
                    m_perr = r[64];
                    m_pid  = g;
                    m_last = g;
                    m_rem  = mlat(mfs);
                    m_ph   = 1;
                end
                1: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_ph = 2; m_valid = 1'b1; m_y = m_py; m_id = m_pid; m_err = m_perr;
                    end
                end
                default: if (res_ready) begin
                    m_valid = 1'b0;
                    m_ph = 0;
                end
            endcase
        end
    end

    // One op through requester id with hand-computed expectations. poke keeps the
    // other requester asserting valid while busy; hold delays res_ready.
    task automatic do_op(input string nm, input bit now, input logic id, input logic [4:0] fs,
                         input logic [63:0] s, input logic [63:0] t, input logic [63:0] exp_y,
                         input logic exp_err, input int exp_lat, input int hold, input bit poke);
        int n;
        if (!now) begin
            @(posedge clk); #1;
        end
        req_valid = id ? 2'b10 : 2'b01;
        if (id) begin
            req_fs[9:5] = fs; req_s[127:64] = s; req_t[127:64] = t;
        end else begin
            req_fs[4:0] = fs; req_s[63:0] = s; req_t[63:0] = t;
        end
        @(negedge clk);
        chk({nm, ".grant"}, 64'(req_ready), id ? 64'd2 : 64'd1);
        @(posedge clk); #1;
        req_valid = poke ? (id ? 2'b01 : 2'b10) : 2'b00;
        req_s  = {$urandom, $urandom, $urandom, $urandom};
        req_t  = {$urandom, $urandom, $urandom, $urandom};
        req_fs = 10'($urandom);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) break;
            chk({nm, ".busy_ready"}, 64'(req_ready), 64'd0);
            n++;
        end
        chk({nm, ".latency"}, 64'(n), 64'(exp_lat));
        chk({nm, ".y"},   res_y,          exp_y);
        chk({nm, ".id"},  64'(res_id),    64'(id));
        chk({nm, ".err"}, 64'(res_err),   64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, ".hold_valid"}, 64'(res_valid), 64'd1);
            chk({nm, ".hold_y"},     res_y,          exp_y);
            chk({nm, ".hold_id"},    64'(res_id),    64'(id));
            chk({nm, ".hold_ready"}, 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          gseq[$];
        logic [3:0]  gp;
        bit          seen;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        do_op("t1_add", 0, 1'b0, 5'h02, D1_5, D2_25, 64'h400E_0000_0000_0000, 1'b0, 2, 0, 0);
        do_op("t2_div", 0, 1'b1, 5'h1F, D1_0, D4_0, 64'h3FD0_0000_0000_0000, 1'b0, 12, 0, 1);

        @(posedge clk); #1;
        req_fs = {5'h1E, 5'h1E}; req_s = {D2_0, D2_0}; req_t = {D3_0, D3_0};
        req_valid = 2'b11; res_ready = 1'b1;
        for (int i = 0; i < 100 && gseq.size() < 4; i++) begin
            @(negedge clk);
            if (res_valid) chk("t3.y", res_y, 64'h4018_0000_0000_0000);
            if (req_ready != 2'b00) gseq.push_back(int'(req_ready[1]));
        end
        @(posedge clk); #1 req_valid = 2'b00;
        gp = '0;
        foreach (gseq[i]) if (i < 4) gp[i] = gseq[i][0];
        chk("t3.ngrants", 64'(gseq.size()), 64'd4);
        chk("t3.order",   64'(gp),          64'b1010);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) chk("t3.y_last", res_y, 64'h4018_0000_0000_0000);
        end
        @(posedge clk); #1 res_ready = 1'b0;

        do_op("t4_hold", 0, 1'b0, 5'h00, D2_0, D3_0, D2_0, 1'b0, 1, 20, 1);
        do_op("t4_next", 1, 1'b1, 5'h01, D1_0, DM2_0, DM2_0, 1'b0, 1, 0, 0);

        do_op("t5_bad",  0, 1'b0, 5'h07, D1_0, D1_0, 64'd0, 1'b1, 1, 0, 0);
        do_op("t5_add",  0, 1'b1, 5'h02, D1_0, D1_0, D2_0, 1'b0, 2, 0, 0);
        do_op("t5_zero", 0, 1'b0, 5'h13, D5_0, D3_0, 64'd0, 1'b0, 1, 0, 0);
        do_op("sub",     0, 1'b1, 5'h03, D5_0, D1_5, 64'h400C_0000_0000_0000, 1'b0, 2, 0, 0);

        @(posedge clk); #1;
        req_valid = 2'b01; req_fs[4:0] = 5'h1F; req_s[63:0] = D1_0; req_t[63:0] = D4_0;
        @(negedge clk);
        chk("t6.grant", 64'(req_ready), 64'd1);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("t6.rst_valid", 64'(res_valid), 64'd0);
        chk("t6.rst_y",     res_y,          64'd0);
        chk("t6.rst_id",    64'(res_id),    64'd0);
        chk("t6.rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        req_valid = 2'b11; req_fs = {5'h01, 5'h00}; req_s = {D4_0, D3_0}; req_t = {D5_0, D2_0};
        @(negedge clk);
        chk("t6.first_grant", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 2'b00; res_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid && !seen) begin
                seen = 1'b1;
                chk("t6.after_y", res_y, D3_0);
            end
        end
        chk("t6.after_seen", 64'(seen), 64'd1);
        @(posedge clk); #1 res_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
